// File: rtl/pos_broadcast_ctrl_if.sv
// Upstream position stream bundle for pos_broadcast_ctrl.
// The master drives position beats and the slave (the controller) returns ready.
interface pos_broadcast_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      in_pos_valid;
    logic                      in_pos_last;
    logic [3*DATA_WIDTH-1:0]   in_pos;
    logic                      in_pos_ready;

    modport master (
        output in_pos_valid,
        output in_pos_last,
        output in_pos,
        input  in_pos_ready
    );

    modport slave (
        input  in_pos_valid,
        input  in_pos_last,
        input  in_pos,
        output in_pos_ready
    );
endinterface

// File: rtl/pos_broadcast_ctrl.sv
// pos_broadcast_ctrl
// Takes post-motion-update particle positions, derives each particle's destination
// cell from the top CELL_ID_WIDTH bits of every coordinate and broadcasts
// {data, dst_cell, valid} to all position caches. motion_update_enable frames the
// broadcast; it is then held low for DRAIN_CYCLES so caches can commit their counts
// and swap buffers before done pulses.
// Optional feature macro: POS_BCAST_COUNT_CHECK_EN adds an expected_count input,
// captured on start and compared against the broadcast count when the frame ends.
module pos_broadcast_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int CELL_ID_WIDTH = 4,
    parameter int CELL_NUM      = 4,
    parameter int CNT_WIDTH     = 12,
    parameter int DRAIN_CYCLES  = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
`ifdef POS_BCAST_COUNT_CHECK_EN
    input  logic [CNT_WIDTH-1:0]         expected_count,
`endif
    pos_broadcast_ctrl_if.slave          up,
    output logic                         motion_update_enable,
    output logic [3*DATA_WIDTH-1:0]      out_data,
    output logic [3*CELL_ID_WIDTH-1:0]   out_data_dst_cell,
    output logic                         out_data_valid,
    output logic [CNT_WIDTH-1:0]         out_particle_count,
    output logic                         busy,
    output logic                         done,
    output logic                         error
);

    // Cell index arithmetic runs two bits wider so 2*CELL_NUM never overflows.
    localparam int KW = CELL_ID_WIDTH + 2;
    localparam logic [KW-1:0] CN_E   = KW'(CELL_NUM);
    localparam logic [KW-1:0] CN2_E  = KW'(2 * CELL_NUM);
    localparam logic [KW-1:0] ONE_E  = KW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_STREAM = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Returns {range_fault, cell_id}: ids run 1..CELL_NUM, one period of wrap is
    // folded back, anything further is clamped to CELL_NUM and flagged.
    function automatic logic [CELL_ID_WIDTH:0] cell_of(input logic [DATA_WIDTH-1:0] coord);
        logic [KW-1:0] k_e;
        logic [KW-1:0] id_e;
        k_e = {2'b00, coord[DATA_WIDTH-1 -: CELL_ID_WIDTH]};
        if (k_e < CN_E) begin
            id_e    = k_e + ONE_E;
            cell_of = {1'b0, id_e[CELL_ID_WIDTH-1:0]};
        end else if (k_e < CN2_E) begin
            id_e    = k_e - CN_E + ONE_E;
            cell_of = {1'b0, id_e[CELL_ID_WIDTH-1:0]};
        end else begin
            cell_of = {1'b1, CN_E[CELL_ID_WIDTH-1:0]};
        end
    endfunction

    state_t                        state_r;
    logic                          ready_r;
    logic                          enable_r;
    logic                          busy_r;
    logic                          done_r;
    logic                          error_r;
    logic [CNT_WIDTH-1:0]          count_r;
    logic [DRAIN_W-1:0]            drain_cnt_r;
    logic [3*DATA_WIDTH-1:0]       out_data_r;
    logic [3*CELL_ID_WIDTH-1:0]    out_dst_r;
    logic                          out_valid_r;
`ifdef POS_BCAST_COUNT_CHECK_EN
    logic [CNT_WIDTH-1:0]          expected_r;
`endif

    logic                          accept_s;
    logic [CELL_ID_WIDTH:0]        cell_x_s;
    logic [CELL_ID_WIDTH:0]        cell_y_s;
    logic [CELL_ID_WIDTH:0]        cell_z_s;
    logic                          range_fault_s;

    // Beat acceptance and per-axis destination cell of the incoming beat.
    always_comb begin
        accept_s      = up.in_pos_valid & ready_r;
        cell_x_s      = cell_of(up.in_pos[DATA_WIDTH-1:0]);
        cell_y_s      = cell_of(up.in_pos[2*DATA_WIDTH-1:DATA_WIDTH]);
        cell_z_s      = cell_of(up.in_pos[3*DATA_WIDTH-1:2*DATA_WIDTH]);
        range_fault_s = cell_x_s[CELL_ID_WIDTH] | cell_y_s[CELL_ID_WIDTH] | cell_z_s[CELL_ID_WIDTH];
    end

    // Frame FSM with registered broadcast, counter and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            ready_r     <= 1'b0;
            enable_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            count_r     <= '0;
            drain_cnt_r <= '0;
            out_data_r  <= '0;
            out_dst_r   <= '0;
            out_valid_r <= 1'b0;
`ifdef POS_BCAST_COUNT_CHECK_EN
            expected_r  <= '0;
`endif
        end else begin
            done_r      <= 1'b0;
            out_valid_r <= accept_s;
            if (accept_s) begin
                out_data_r <= up.in_pos;
                out_dst_r  <= {cell_x_s[CELL_ID_WIDTH-1:0], cell_y_s[CELL_ID_WIDTH-1:0],
                               cell_z_s[CELL_ID_WIDTH-1:0]};
                if (count_r != CNT_MAX) begin
                    count_r <= count_r + CNT_ONE;
                end else begin
                    count_r <= count_r;
                end
                if (range_fault_s) begin
                    error_r <= 1'b1;
                end else begin
                    error_r <= error_r;
                end
            end else begin
                out_data_r <= '0;
                out_dst_r  <= '0;
            end

            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r  <= ST_ARM;
                        enable_r <= 1'b1;
                        busy_r   <= 1'b1;
                        count_r  <= '0;
                        error_r  <= 1'b0;
`ifdef POS_BCAST_COUNT_CHECK_EN
                        expected_r <= expected_count;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ARM: begin
                    state_r <= ST_STREAM;
                    ready_r <= 1'b1;
                end
                ST_STREAM: begin
                    if (accept_s && up.in_pos_last) begin
                        state_r <= ST_FLUSH;
                        ready_r <= 1'b0;
                    end else begin
                        state_r <= ST_STREAM;
                    end
                end
                ST_FLUSH: begin
                    // The last beat is on the outputs now, still inside the enable window.
                    state_r     <= ST_DRAIN;
                    enable_r    <= 1'b0;
                    drain_cnt_r <= '0;
                end
                ST_DRAIN: begin
                    if (drain_cnt_r == DRAIN_LAST) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
`ifdef POS_BCAST_COUNT_CHECK_EN
                        if (count_r != expected_r) begin
                            error_r <= 1'b1;
                        end else begin
                            error_r <= error_r;
                        end
`endif
                    end else begin
                        drain_cnt_r <= drain_cnt_r + DRAIN_ONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    ready_r  <= 1'b0;
                    enable_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign up.in_pos_ready         = ready_r;
    assign motion_update_enable    = enable_r;
    assign out_data                = out_data_r;
    assign out_data_dst_cell       = out_dst_r;
    assign out_data_valid          = out_valid_r;
    assign out_particle_count      = count_r;
    assign busy                    = busy_r;
    assign done                    = done_r;
    assign error                   = error_r;

endmodule

// File: tb/tb_pos_broadcast_ctrl.sv
// Directed testbench for pos_broadcast_ctrl (default parameters).
module tb_pos_broadcast_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        enable;
    logic [95:0] out_data;
    logic [11:0] dst;
    logic        out_valid;
    logic [11:0] count;
    logic        busy;
    logic        done;
    logic        error;
`ifdef POS_BCAST_COUNT_CHECK_EN
    logic [11:0] expected_count = 12'd0;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pos_broadcast_ctrl_if #(.DATA_WIDTH(32)) bus ();

    pos_broadcast_ctrl dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
`ifdef POS_BCAST_COUNT_CHECK_EN
        .expected_count       (expected_count),
`endif
        .up                   (bus.slave),
        .motion_update_enable (enable),
        .out_data             (out_data),
        .out_data_dst_cell    (dst),
        .out_data_valid       (out_valid),
        .out_particle_count   (count),
        .busy                 (busy),
        .done                 (done),
        .error                (error)
    );

    // Behavioural Pos_Cache_3_1_2: counts its beats while enabled, commits to address 0 when enable falls.
    logic        en_d;
    logic [11:0] cache_cnt;
    logic [11:0] cache_mem0;
    int          valid_seen = 0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_d       <= 1'b0;
            cache_cnt  <= 12'd0;
            cache_mem0 <= 12'd0;
        end else begin
            en_d <= enable;
            if (en_d && !enable) begin
                cache_mem0 <= cache_cnt;
                cache_cnt  <= 12'd0;
            end else if (enable && out_valid && dst == 12'h312) begin
                cache_cnt <= cache_cnt + 12'd1;
            end
            if (out_valid) valid_seen <= valid_seen + 1;
        end
    end

    function automatic logic [95:0] mkpos(input logic [3:0] kx, input logic [3:0] ky, input logic [3:0] kz);
        return {kz, 28'h7654321, ky, 28'h0ABCDEF, kx, 28'h1234567};
    endfunction

    task automatic idle_bus;
        bus.in_pos_valid = 1'b0;
        bus.in_pos_last  = 1'b0;
        bus.in_pos       = 96'd0;
    endtask

    task automatic do_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic beat(input logic [3:0] kx, input logic [3:0] ky, input logic [3:0] kz, input logic last);
        bus.in_pos_valid = 1'b1;
        bus.in_pos_last  = last;
        bus.in_pos       = mkpos(kx, ky, kz);
        @(negedge clk);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if ({enable, busy, done, error, out_valid, bus.in_pos_ready} !== 6'b0) begin failures++; $display("FAIL rst_flags got=%b exp=000000", {enable, busy, done, error, out_valid, bus.in_pos_ready}); end
        checks++; if (count !== 12'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
        checks++; if (out_data !== 96'd0 || dst !== 12'd0) begin failures++; $display("FAIL rst_data got=%h/%h exp=0/0", out_data, dst); end
        rst = 1'b1;
        @(negedge clk);
        do_start;
        @(negedge clk);
        beat(4'd0, 4'd0, 4'd0, 1'b0);
        idle_bus;
        checks++; if (count !== 12'd1 || out_valid !== 1'b1) begin failures++; $display("FAIL pre_rst_beat got=%0d/%b exp=1/1", count, out_valid); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({enable, busy, out_valid, bus.in_pos_ready} !== 4'b0) begin failures++; $display("FAIL async_rst_flags got=%b exp=0000", {enable, busy, out_valid, bus.in_pos_ready}); end
        checks++; if (count !== 12'd0 || dst !== 12'd0) begin failures++; $display("FAIL async_rst_count got=%0d/%h exp=0/0", count, dst); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if ({enable, busy, bus.in_pos_ready} !== 3'b0) begin failures++; $display("FAIL post_rst_idle got=%b exp=000", {enable, busy, bus.in_pos_ready}); end
    endtask

    task automatic test_three_beats;
        do_start;
        checks++; if ({enable, busy, bus.in_pos_ready} !== 3'b110) begin failures++; $display("FAIL arm_flags got=%b exp=110", {enable, busy, bus.in_pos_ready}); end
        @(negedge clk);
        checks++; if (bus.in_pos_ready !== 1'b1) begin failures++; $display("FAIL stream_ready got=%b exp=1", bus.in_pos_ready); end
        beat(4'd0, 4'd0, 4'd0, 1'b0);
        checks++; if (out_valid !== 1'b1 || dst !== 12'h111 || out_data !== mkpos(4'd0, 4'd0, 4'd0)) begin failures++; $display("FAIL beat1 got=%b/%h/%h exp=1/111/%h", out_valid, dst, out_data, mkpos(4'd0, 4'd0, 4'd0)); end
        beat(4'd2, 4'd0, 4'd1, 1'b0);
        checks++; if (out_valid !== 1'b1 || dst !== 12'h312 || count !== 12'd2) begin failures++; $display("FAIL beat2 got=%b/%h/%0d exp=1/312/2", out_valid, dst, count); end
        beat(4'd3, 4'd3, 4'd3, 1'b1);
        idle_bus;
        checks++; if (out_valid !== 1'b1 || dst !== 12'h444 || enable !== 1'b1 || bus.in_pos_ready !== 1'b0) begin failures++; $display("FAIL beat3 got=%b/%h/%b/%b exp=1/444/1/0", out_valid, dst, enable, bus.in_pos_ready); end
        checks++; if (count !== 12'd3) begin failures++; $display("FAIL t2_count got=%0d exp=3", count); end
        @(negedge clk);
        checks++; if (enable !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL enable_fall got=%b/%b exp=0/0", enable, out_valid); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_early got=%b exp=0", done); end
        @(negedge clk);
        checks++; if (done !== 1'b1 || busy !== 1'b1 || error !== 1'b0 || count !== 12'd3) begin failures++; $display("FAIL t2_done got=%b/%b/%b/%0d exp=1/1/0/3", done, busy, error, count); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL t2_idle got=%b/%b exp=0/0", done, busy); end
        checks++; if (cache_mem0 !== 12'd1) begin failures++; $display("FAIL t2_cache got=%0d exp=1", cache_mem0); end
    endtask

    task automatic test_wrap;
        bit ok;
        do_start;
        @(negedge clk);
        beat(4'd4, 4'd0, 4'd0, 1'b0);
        checks++; if (dst !== 12'h111 || error !== 1'b0) begin failures++; $display("FAIL wrap_k4 got=%h/%b exp=111/0", dst, error); end
        beat(4'd5, 4'd0, 4'd0, 1'b0);
        checks++; if (dst !== 12'h211 || error !== 1'b0) begin failures++; $display("FAIL wrap_k5 got=%h/%b exp=211/0", dst, error); end
        beat(4'd7, 4'd0, 4'd0, 1'b0);
        checks++; if (dst !== 12'h411 || error !== 1'b0) begin failures++; $display("FAIL wrap_k7 got=%h/%b exp=411/0", dst, error); end
        beat(4'd9, 4'd0, 4'd0, 1'b1);
        idle_bus;
        checks++; if (dst !== 12'h411 || error !== 1'b1 || out_valid !== 1'b1) begin failures++; $display("FAIL range_k9 got=%h/%b/%b exp=411/1/1", dst, error, out_valid); end
        wait_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL t3_done_timeout got=0 exp=1"); end
        checks++; if (error !== 1'b1 || count !== 12'd4) begin failures++; $display("FAIL t3_sticky got=%b/%0d exp=1/4", error, count); end
        @(negedge clk);
        checks++; if (cache_mem0 !== 12'd0) begin failures++; $display("FAIL t3_cache got=%0d exp=0", cache_mem0); end
    endtask

    task automatic test_single_beat;
        bit ok;
        do_start;
        checks++; if (error !== 1'b0 || count !== 12'd0) begin failures++; $display("FAIL start_clear got=%b/%0d exp=0/0", error, count); end
        @(negedge clk);
        beat(4'd2, 4'd0, 4'd1, 1'b1);
        idle_bus;
        checks++; if (count !== 12'd1 || dst !== 12'h312) begin failures++; $display("FAIL single_beat got=%0d/%h exp=1/312", count, dst); end
        wait_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL t4_done_timeout got=0 exp=1"); end
        checks++; if (count !== 12'd1 || cache_mem0 !== 12'd1) begin failures++; $display("FAIL t4_cache got=%0d/%0d exp=1/1", count, cache_mem0); end
        @(negedge clk);
    endtask

    task automatic test_gaps_and_start;
        bit ok;
        int v0;
        v0 = valid_seen;
        do_start;
        @(negedge clk);
        beat(4'd0, 4'd0, 4'd0, 1'b0);
        idle_bus;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || dst !== 12'd0 || out_data !== 96'd0) begin failures++; $display("FAIL gap_zero got=%b/%h exp=0/000", out_valid, dst); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (count !== 12'd1 || bus.in_pos_ready !== 1'b1 || enable !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL start_in_stream got=%0d/%b/%b/%b exp=1/1/1/0", count, bus.in_pos_ready, enable, out_valid); end
        beat(4'd1, 4'd1, 4'd1, 1'b0);
        idle_bus;
        @(negedge clk);
        @(negedge clk);
        beat(4'd2, 4'd2, 4'd2, 1'b1);
        idle_bus;
        wait_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL t5_done_timeout got=0 exp=1"); end
        checks++; if (count !== 12'd3 || (valid_seen - v0) !== 3) begin failures++; $display("FAIL t5_count got=%0d/%0d exp=3/3", count, valid_seen - v0); end
        @(negedge clk);
        bus.in_pos_valid = 1'b1;
        bus.in_pos       = mkpos(4'd1, 4'd1, 4'd1);
        @(negedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0 || bus.in_pos_ready !== 1'b0 || out_valid !== 1'b0 || count !== 12'd3) begin failures++; $display("FAIL idle_no_accept got=%b/%b/%b/%0d exp=0/0/0/3", busy, bus.in_pos_ready, out_valid, count); end
        idle_bus;
    endtask

    task automatic test_saturate;
        bit ok;
        do_start;
        @(negedge clk);
        bus.in_pos_valid = 1'b1;
        bus.in_pos       = mkpos(4'd0, 4'd0, 4'd0);
        repeat (4100) @(negedge clk);
        checks++; if (count !== 12'hFFF) begin failures++; $display("FAIL count_sat got=%0d exp=4095", count); end
        bus.in_pos_last = 1'b1;
        @(negedge clk);
        idle_bus;
        wait_done(ok);
        checks++; if (!ok || count !== 12'hFFF) begin failures++; $display("FAIL sat_done got=%b/%0d exp=1/4095", ok, count); end
        @(negedge clk);
    endtask

`ifdef POS_BCAST_COUNT_CHECK_EN
    task automatic test_count_check;
        bit ok;
        expected_count = 12'd5;
        do_start;
        expected_count = 12'd4;
        @(negedge clk);
        for (int i = 0; i < 4; i++) beat(4'd0, 4'd0, 4'd0, (i == 3));
        idle_bus;
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL cc_pre_done got=%b exp=0", error); end
        wait_done(ok);
        checks++; if (!ok || error !== 1'b1) begin failures++; $display("FAIL cc_mismatch got=%b/%b exp=1/1", ok, error); end
        @(negedge clk);
        do_start;
        expected_count = 12'd0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) beat(4'd0, 4'd0, 4'd0, (i == 3));
        idle_bus;
        wait_done(ok);
        checks++; if (!ok || error !== 1'b0) begin failures++; $display("FAIL cc_match got=%b/%b exp=1/0", ok, error); end
        @(negedge clk);
    endtask
`endif

    initial begin
        idle_bus;
        test_reset;
        test_three_beats;
        test_wrap;
        test_single_beat;
        test_gaps_and_start;
        test_saturate;
`ifdef POS_BCAST_COUNT_CHECK_EN
        test_count_check;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
